// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: turns the registered PC into imem word reads
// and hands fetched instructions to decode over a valid/ready handshake.
module ifetch_ctrl #(
    parameter logic [31:0] PC_BASE = 32'h0040_0000,
    parameter int          ADDR_W  = 10,
    parameter int          TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    output logic              pc_ena,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              addr_err,
    output logic              fetch_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_ADV  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [15:0] count;
    logic        drop;
    logic [31:0] req_pc;
    logic [31:0] idx;
    logic        pc_ok;

    // Range check uses the full 32-bit word index before it is truncated to ADDR_W.
    assign idx   = (pc - PC_BASE) >> 2;
    assign pc_ok = (pc[1:0] == 2'b00) && (pc >= PC_BASE) && ((idx >> ADDR_W) == 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            drop       <= 1'b0;
            req_pc     <= '0;
            pc_ena     <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            addr_err   <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pc_ok) begin
                        imem_req  <= 1'b1;
                        imem_addr <= idx[ADDR_W-1:0];
                        req_pc    <= pc;
                        count     <= '0;
                        state     <= S_WAIT;
                    end else begin
                        addr_err <= 1'b1;
                        state    <= S_ERR;
                    end
                end
                S_WAIT: begin
                    // A flush arriving on the same edge as the ack also discards the data.
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (drop || flush) begin
                            drop   <= 1'b0;
                            pc_ena <= 1'b1;
                            state  <= S_ADV;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= req_pc;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (count == TIMEOUT_LAST) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        drop      <= 1'b0;
                        state     <= S_ERR;
                    end else begin
                        count <= count + 16'd1;
                        if (flush) begin
                            drop <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush || inst_ready) begin
                        inst_valid <= 1'b0;
                        pc_ena     <= 1'b1;
                        state      <= S_ADV;
                    end
                end
                S_ADV: begin
                    pc_ena <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    if (flush) begin
                        addr_err  <= 1'b0;
                        fetch_err <= 1'b0;
                        pc_ena    <= 1'b1;
                        state     <= S_ADV;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: drives inputs and samples outputs on negedge,
// one posedge per step, against hand-computed expected values.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_ena;
    logic        flush;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        addr_err;
    logic        fetch_err;

    int vectors = 0;
    int errors  = 0;

    ifetch_ctrl #(
        .PC_BASE(32'h0040_0000),
        .ADDR_W (10),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .pc_ena    (pc_ena),
        .flush     (flush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .addr_err  (addr_err),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] new_pc, input logic new_flush,
                                 input logic new_ack, input logic [31:0] new_rdata,
                                 input logic new_ready);
        pc         = new_pc;
        flush      = new_flush;
        imem_ack   = new_ack;
        imem_rdata = new_rdata;
        inst_ready = new_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".pc_ena"},     32'(pc_ena),     32'd0);
        checkOutput({tag, ".imem_req"},   32'(imem_req),   32'd0);
        checkOutput({tag, ".imem_addr"},  32'(imem_addr),  32'd0);
        checkOutput({tag, ".inst"},       inst,            32'd0);
        checkOutput({tag, ".inst_pc"},    inst_pc,         32'd0);
        checkOutput({tag, ".inst_valid"}, 32'(inst_valid), 32'd0);
        checkOutput({tag, ".addr_err"},   32'(addr_err),   32'd0);
        checkOutput({tag, ".fetch_err"},  32'(fetch_err),  32'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(32'h0040_0000, 1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        checkIdleOutputs("reset");

        // Basic fetch with 1-cycle ack and ready high.
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("f0.req", 32'(imem_req), 32'd1);
        checkOutput("f0.addr", 32'(imem_addr), 32'd0);
        checkOutput("f0.valid_low", 32'(inst_valid), 32'd0);
        applyStimulus(32'h0040_0000, 1'b0, 1'b1, 32'h2008_0001, 1'b1);
        tick();
        checkOutput("f0.valid", 32'(inst_valid), 32'd1);
        checkOutput("f0.inst", inst, 32'h2008_0001);
        checkOutput("f0.inst_pc", inst_pc, 32'h0040_0000);
        checkOutput("f0.req_drop", 32'(imem_req), 32'd0);
        checkOutput("f0.pc_ena_low", 32'(pc_ena), 32'd0);
        applyStimulus(32'h0040_0000, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("f0.pc_ena", 32'(pc_ena), 32'd1);
        checkOutput("f0.consumed", 32'(inst_valid), 32'd0);
        applyStimulus(32'h0040_0004, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("f0.pc_ena_end", 32'(pc_ena), 32'd0);

        // Decode stalls for 5 cycles in HOLD.
        tick();
        checkOutput("f1.req", 32'(imem_req), 32'd1);
        checkOutput("f1.addr", 32'(imem_addr), 32'd1);
        applyStimulus(32'h0040_0004, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
        tick();
        applyStimulus(32'h0040_0004, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall.valid", 32'(inst_valid), 32'd1);
            checkOutput("stall.inst", inst, 32'h1111_1111);
            checkOutput("stall.inst_pc", inst_pc, 32'h0040_0004);
            checkOutput("stall.pc_ena", 32'(pc_ena), 32'd0);
            checkOutput("stall.req", 32'(imem_req), 32'd0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        checkOutput("stall.pc_ena_pulse", 32'(pc_ena), 32'd1);
        checkOutput("stall.valid_drop", 32'(inst_valid), 32'd0);
        applyStimulus(32'h0040_0002, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("stall.pc_ena_end", 32'(pc_ena), 32'd0);

        // Misaligned PC.
        tick();
        checkOutput("mis.addr_err", 32'(addr_err), 32'd1);
        checkOutput("mis.req", 32'(imem_req), 32'd0);
        tick();
        checkOutput("mis.sticky", 32'(addr_err), 32'd1);
        checkOutput("mis.req_hold", 32'(imem_req), 32'd0);
        checkOutput("mis.pc_ena_hold", 32'(pc_ena), 32'd0);
        flush = 1'b1;
        tick();
        checkOutput("mis.clear", 32'(addr_err), 32'd0);
        checkOutput("mis.pc_ena", 32'(pc_ena), 32'd1);
        applyStimulus(32'h0040_1000, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("mis.pc_ena_end", 32'(pc_ena), 32'd0);

        // Out-of-range PC: index 1024 does not fit in 10 bits.
        tick();
        checkOutput("oor.addr_err", 32'(addr_err), 32'd1);
        checkOutput("oor.req", 32'(imem_req), 32'd0);
        flush = 1'b1;
        tick();
        checkOutput("oor.clear", 32'(addr_err), 32'd0);
        checkOutput("oor.pc_ena", 32'(pc_ena), 32'd1);
        applyStimulus(32'h0040_0008, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();

        // Flush during WAIT: the late data is dropped.
        tick();
        checkOutput("fw.req", 32'(imem_req), 32'd1);
        checkOutput("fw.addr", 32'(imem_addr), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fw.req_held", 32'(imem_req), 32'd1);
        checkOutput("fw.no_ena", 32'(pc_ena), 32'd0);
        tick();
        checkOutput("fw.req_held2", 32'(imem_req), 32'd1);
        applyStimulus(32'h0040_0008, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        checkOutput("fw.pc_ena", 32'(pc_ena), 32'd1);
        checkOutput("fw.no_valid", 32'(inst_valid), 32'd0);
        checkOutput("fw.req_drop", 32'(imem_req), 32'd0);
        applyStimulus(32'h0040_000C, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("fw.pc_ena_end", 32'(pc_ena), 32'd0);
        checkOutput("fw.no_valid2", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("fw.next_req", 32'(imem_req), 32'd1);
        checkOutput("fw.next_addr", 32'(imem_addr), 32'd3);
        applyStimulus(32'h0040_000C, 1'b0, 1'b1, 32'h3333_3333, 1'b1);
        tick();
        checkOutput("fw.next_inst", inst, 32'h3333_3333);
        checkOutput("fw.next_inst_pc", inst_pc, 32'h0040_000C);
        checkOutput("fw.next_valid", 32'(inst_valid), 32'd1);
        applyStimulus(32'h0040_000C, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("fw.next_pc_ena", 32'(pc_ena), 32'd1);
        applyStimulus(32'h0040_0010, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();

        // Timeout: no ack, TIMEOUT=4.
        tick();
        checkOutput("to.addr", 32'(imem_addr), 32'd4);
        for (int i = 0; i < 3; i++) begin
            checkOutput("to.req_high", 32'(imem_req), 32'd1);
            checkOutput("to.no_err", 32'(fetch_err), 32'd0);
            tick();
        end
        checkOutput("to.req_last", 32'(imem_req), 32'd1);
        tick();
        checkOutput("to.req_drop", 32'(imem_req), 32'd0);
        checkOutput("to.fetch_err", 32'(fetch_err), 32'd1);
        applyStimulus(32'h0040_0010, 1'b0, 1'b1, 32'h5555_5555, 1'b1);
        tick();
        checkOutput("to.late_valid", 32'(inst_valid), 32'd0);
        checkOutput("to.late_inst", inst, 32'h3333_3333);
        checkOutput("to.late_err", 32'(fetch_err), 32'd1);
        checkOutput("to.late_ena", 32'(pc_ena), 32'd0);
        applyStimulus(32'h0040_0010, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("to.clear", 32'(fetch_err), 32'd0);
        checkOutput("to.pc_ena", 32'(pc_ena), 32'd1);
        applyStimulus(32'h0040_0000, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        checkOutput("rw.req", 32'(imem_req), 32'd1);

        // Async reset in WAIT, then a stale ack is ignored.
        #2;
        rst = 1'b1;
        #1;
        checkIdleOutputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h0040_0000, 1'b0, 1'b1, 32'h6666_6666, 1'b1);
        tick();
        checkOutput("rw.stale_valid", 32'(inst_valid), 32'd0);
        checkOutput("rw.fresh_req", 32'(imem_req), 32'd1);
        checkOutput("rw.fresh_addr", 32'(imem_addr), 32'd0);
        applyStimulus(32'h0040_0000, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("rw.still_wait", 32'(imem_req), 32'd1);
        checkOutput("rw.no_valid", 32'(inst_valid), 32'd0);
        applyStimulus(32'h0040_0000, 1'b0, 1'b1, 32'h2008_0001, 1'b1);
        tick();
        checkOutput("rw.valid", 32'(inst_valid), 32'd1);
        checkOutput("rw.inst", inst, 32'h2008_0001);
        checkOutput("rw.inst_pc", inst_pc, 32'h0040_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch controller directly downstream of the PC register. It takes the registered PC, issues word reads to instruction memory over a variable-latency req/ack interface, and presents the fetched instruction to decode with a valid/ready handshake. It drives the PC register's enable so the PC advances only after an instruction is consumed or a redirect occurs. It also detects misaligned or out-of-range PCs and memory timeouts.

Parameters:
PC_BASE, 32'h0040_0000, byte address of instruction memory word 0; also the PC reset vector.
ADDR_W, 10, instruction memory word-address width (1024 words).
TIMEOUT, 255, maximum cycles in WAIT without imem_ack before a fetch error; 1..65535.

Ports:
clk  in  1  clock; all state in this block updates on posedge.
rst  in  1  asynchronous, active-high reset.
pc  in  32  current PC from the PC register, which updates on negedge clk.
pc_ena  out  1  enable to the PC register; high for exactly one full clk cycle per advance or redirect.
flush  in  1  redirect request; the PC register's input carries the target while this block asserts pc_ena.
imem_req  out  1  memory read request, registered.
imem_addr  out  ADDR_W  word address = (pc - PC_BASE) >> 2, registered.
imem_ack  in  1  read data valid; sampled only in WAIT.
imem_rdata  in  32  read data, captured when imem_ack is high.
inst  out  32  fetched instruction.
inst_pc  out  32  PC of inst.
inst_valid  out  1  inst and inst_pc are valid.
inst_ready  in  1  decode accepts the instruction.
addr_err  out  1  sticky: misaligned or out-of-range PC.
fetch_err  out  1  sticky: imem timeout.

Behaviour:
- Registered outputs: imem_req, imem_addr, inst, inst_pc, inst_valid, pc_ena, addr_err, fetch_err. All outputs are registered; none is combinational.
- Reset (async): state IDLE; all outputs 0; timeout counter 0; drop flag 0. Reset mid-fetch abandons the request immediately; a late imem_ack is ignored.
- States: IDLE, WAIT, HOLD, ADV, ERR.
- IDLE: pc is validated.
  - Valid PC (pc[1:0]==0, pc>=PC_BASE, (pc-PC_BASE)>>2 < 2^ADDR_W): imem_req<=1, imem_addr<=index, req_pc<=pc, counter<=0, next state WAIT.
  - Invalid PC: addr_err<=1, next state ERR, no request issued.
- WAIT: imem_req held at 1 and counter increments each cycle.
  - On imem_ack with drop==0: imem_req<=0, inst<=imem_rdata, inst_pc<=req_pc, inst_valid<=1, next state HOLD.
  - On imem_ack with drop==1: imem_req<=0, drop<=0, data discarded, next state ADV.
  - Timeout (counter reaches TIMEOUT-1 with no ack): imem_req<=0, fetch_err<=1, drop<=0, next state ERR.
  - flush in WAIT: drop<=1; the state does not change until ack or timeout.
- HOLD: inst_valid stays 1 and inst/inst_pc stay stable until the handshake.
  - On posedge with inst_ready==1: inst_valid<=0, pc_ena<=1, next state ADV.
  - flush has priority over inst_ready: inst_valid<=0, pc_ena<=1, next state ADV. The instruction is not counted as consumed.
- ADV: pc_ena is 1 for this whole cycle, so the PC loads on the intervening negedge. Next posedge: pc_ena<=0, next state IDLE. flush in ADV is ignored (the load is already in progress).
- ERR: outputs idle except the sticky error flags. flush: clear addr_err and fetch_err, pc_ena<=1, next state ADV.
- Steady-state throughput with 1-cycle ack and ready always high: one instruction per 4 cycles (IDLE, WAIT, HOLD, ADV).
- Address arithmetic: 32-bit unsigned subtract. The range check is done before truncation to ADDR_W.

Test Plan:
- Reset, then release rst with pc=0x0040_0000; imem acks 1 cycle after req with 0x2008_0001 -> imem_addr=0, then inst=0x2008_0001, inst_pc=0x0040_0000, inst_valid=1; with inst_ready=1, pc_ena=1 for exactly one cycle.
- inst_ready held low for 5 cycles in HOLD -> inst_valid and inst stay stable, pc_ena stays 0, imem_req stays 0; raising inst_ready gives one pc_ena pulse.
- pc=0x0040_0002 -> addr_err=1, no imem_req, state ERR; pc=0x0040_1000 with ADDR_W=10 -> addr_err=1; a subsequent flush clears addr_err and pulses pc_ena.
- flush asserted during WAIT, ack 3 cycles later with 0xDEAD_BEEF -> inst_valid never rises, pc_ena pulses after the ack, and the new pc is fetched next.
- TIMEOUT=4 and imem_ack never asserted -> imem_req high 4 cycles then drops, fetch_err=1; a late imem_ack while in ERR has no effect.
- rst asserted during WAIT with imem_req=1 -> all outputs 0 immediately (async); an ack after rst deasserts is ignored, and a fresh fetch of 0x0040_0000 follows.
